// File: rtl/axis_fifo.sv
// axis_fifo: DEPTH-entry AXI-Stream FIFO with first-word-fall-through output,
// occupancy reporting, a registered almost-full flag and a synchronous flush.
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - asynchronous, active-low reset
//   flush          - synchronous, active-high; discards all stored beats
//   s_axis_tvalid  - upstream beat valid
//   s_axis_tdata   - upstream data
//   s_axis_tlast   - upstream end-of-packet
//   s_axis_tready  - FIFO can accept a beat
//   m_axis_tvalid  - head beat valid
//   m_axis_tdata   - head data
//   m_axis_tlast   - head end-of-packet
//   m_axis_tready  - downstream accepts the head beat
//   level          - number of stored beats, 0..DEPTH
//   almost_full    - level >= AF_THRESH, registered
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. s_axis_tready depends only on FIFO state and flush, never on
// s_axis_tvalid. m_axis_tvalid/tdata/tlast hold steady until popped, except
// across a flush or reset.

module axis_fifo #(
  parameter int AXIS_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_axis_tvalid,
  input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [LW-1:0]         level,
  output logic                  almost_full
);

  localparam int AW = LW - 1;

  // Storage holds {tlast, tdata}; it is never reset.
  logic [AXIS_WIDTH:0] mem [DEPTH];

  // Pointers carry one extra wrap bit above the address bits.
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [LW-1:0] level_next;
  logic          ready_en;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // ready_en keeps tready low while reset is held and rises on the first
  // clock edge after release.
  assign s_axis_tready = ready_en & ~full & ~flush;
  assign m_axis_tvalid = ~empty;

  assign push = s_axis_tvalid & s_axis_tready;
  assign pop  = m_axis_tvalid & m_axis_tready;

  // Modular difference of the wrap-bit pointers is exactly 0..DEPTH.
  assign level = wr_ptr - rd_ptr;

  assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[AW-1:0]];

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level + LW'(1);
    end else if (pop && !push) begin
      level_next = level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      almost_full <= 1'b0;
      ready_en    <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      almost_full <= (level_next >= LW'(AF_THRESH));
      if (flush) begin
        // A pop in the flush cycle counts as delivered; the reset of both
        // pointers discards it along with everything else.
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + LW'(1);
        if (pop)  rd_ptr <= rd_ptr + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

endmodule

// File: tb/tb_axis_fifo.sv
module tb_axis_fifo;

  localparam int W   = 32;
  localparam int DEP = 8;
  localparam int AF  = 6;
  localparam int LW  = $clog2(DEP) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          flush;
  logic          s_axis_tvalid;
  logic [W-1:0]  s_axis_tdata;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [LW-1:0] level;
  logic          almost_full;

  axis_fifo #(.AXIS_WIDTH(W), .DEPTH(DEP), .AF_THRESH(AF)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .level         (level),
    .almost_full   (almost_full)
  );

  // ---------------- scoreboard / reference model ----------------
  // The FIFO contents as a plain queue of {tlast, tdata}, head first.
  logic [W:0] exp_q[$];
  bit         model_ready_en = 1'b0;
  bit         last_push;
  bit         last_pop;
  int         pushed_cnt;
  int         delivered_cnt;
  int         max_level;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check("tvalid", 64'(m_axis_tvalid), 64'(sz != 0));
    if (sz != 0) begin
      check("tdata", 64'(m_axis_tdata), 64'(exp_q[0][W-1:0]));
      check("tlast", 64'(m_axis_tlast), 64'(exp_q[0][W]));
    end
    check("level", 64'(level), 64'(sz));
    check("almost_full", 64'(almost_full), 64'(sz >= AF));
    check("s_tready", 64'(s_axis_tready), 64'(model_ready_en && sz < DEP && !flush));
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  // One clock cycle: check at the falling edge, advance the model at the
  // rising edge from the inputs that were held through the cycle.
  task automatic step();
    bit do_push;
    bit do_pop;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (!reset) begin
      exp_q.delete();
      model_ready_en = 1'b0;
    end else begin
      do_push = s_axis_tvalid && model_ready_en && exp_q.size() < DEP && !flush;
      do_pop  = m_axis_tready && exp_q.size() != 0;
      if (do_pop) begin
        void'(exp_q.pop_front());
        delivered_cnt++;
      end
      if (do_push) begin
        exp_q.push_back({s_axis_tlast, s_axis_tdata});
        pushed_cnt++;
      end
      if (flush) exp_q.delete();
      model_ready_en = 1'b1;
    end
    last_push = do_push;
    last_pop  = do_pop;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic offer(input logic [W-1:0] data, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cycles;
    int beat;
    reset = 1'b0;
    drive_idle();
    pushed_cnt    = 0;
    delivered_cnt = 0;
    max_level     = 0;

    // 1. reset then idle
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    check("t1_tready", 64'(s_axis_tready), 64'(1));
    check("t1_level", 64'(level), 64'(0));

    // 2. fill with no drain; the ninth offer must be refused
    for (int i = 1; i <= 9; i++) begin
      offer(W'(i), 1'b0);
      step();
    end
    check("t2_9th_refused", 64'(last_push), 64'(0));
    s_axis_tvalid = 1'b0;
    step();

    // 3. drain in order
    m_axis_tready = 1'b1;
    repeat (10) step();
    check("t3_drained", 64'(delivered_cnt), 64'(8));

    // 4. full-rate streaming across four pointer wraps
    for (int v = 1; v <= 32; v++) begin
      offer(W'(v), 1'b0);
      step();
    end
    s_axis_tvalid = 1'b0;
    step();
    check("t4_delivered", 64'(delivered_cnt), 64'(40));

    // 5. random backpressure, 1000 beats, tlast every 5th beat
    pushed_cnt    = 0;
    delivered_cnt = 0;
    max_level     = 0;
    beat          = 0;
    cycles        = 0;
    s_axis_tvalid = 1'b0;
    while (delivered_cnt < 1000 && cycles < 20000) begin
      if (!s_axis_tvalid || last_push) begin
        if (last_push) beat++;
        if (beat < 1000 && $urandom_range(1, 0) == 1)
          offer($urandom, ((beat + 1) % 5) == 0);
        else
          s_axis_tvalid = 1'b0;
      end
      m_axis_tready = ($urandom_range(1, 0) == 1);
      last_push = 1'b0;
      step();
      cycles++;
    end
    check("t5_delivered", 64'(delivered_cnt), 64'(1000));
    check("t5_max_level_ok", 64'(max_level <= DEP), 64'(1));
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    step();

    // 6a. flush with level 5, then a fresh beat falls through
    for (int i = 0; i < 5; i++) begin
      offer(W'(32'h100 + i), (i == 4));
      step();
    end
    s_axis_tvalid = 1'b0;
    step();
    check("t6_level5", 64'(level), 64'(5));
    flush         = 1'b1;
    m_axis_tready = 1'b1;
    step();
    flush         = 1'b0;
    m_axis_tready = 1'b0;
    check("t6_flush_level", 64'(level), 64'(0));
    check("t6_flush_tvalid", 64'(m_axis_tvalid), 64'(0));
    offer(W'(32'hA5), 1'b1);
    step();
    s_axis_tvalid = 1'b0;
    step();
    m_axis_tready = 1'b1;
    step();

    // 6b. asynchronous reset mid-stream
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      offer(W'(32'h200 + i), 1'b0);
      step();
    end
    s_axis_tvalid = 1'b0;
    #2;
    reset = 1'b0;
    exp_q.delete();
    model_ready_en = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("t6_rst_level", 64'(level), 64'(0));
    check("t6_rst_af", 64'(almost_full), 64'(0));
    check("t6_rst_tready", 64'(s_axis_tready), 64'(0));
    step();
    step();
    reset = 1'b1;
    step();
    offer(W'(32'h5A), 1'b0);
    step();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
